// File: rtl/uart_cfg_rx_if.sv
// ============================================================================
//  Module      : uart_cfg_rx_if
//  Description : Signal bundle between the Rx pad side and the configuration
//                loader for the oversampling UART receiver.
//                  rx_i          raw UART line, idle high
//                  data_o        last accepted byte
//                  valid_o       one-cycle strobe, data_o valid same cycle
//                  frame_err_o   one-cycle strobe on stop/parity failure
//                  busy_o        receiver is inside a frame
//                  receive_led_o activity LED
//                master : drives the line, consumes the byte stream
//                slave  : the receiver itself
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_cfg_rx_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;
  logic       receive_led_o;

  modport master (
    output rx_i,
    input  data_o, valid_o, frame_err_o, busy_o, receive_led_o
  );

  modport slave (
    input  rx_i,
    output data_o, valid_o, frame_err_o, busy_o, receive_led_o
  );
endinterface

`default_nettype wire

// File: rtl/uart_cfg_rx.sv
// ============================================================================
//  Module      : uart_cfg_rx
//  Description : Oversampling UART receiver (8 data bits, LSB first, one stop
//                bit) for the board-level configuration path. Produces a
//                validated byte with a one-cycle strobe and drives the
//                ReceiveLED activity indication.
//  Ports       : clk    system clock, rising edge
//                reset  asynchronous, active-high
//                bus    uart_cfg_rx_if.slave (rx_i in; data_o, valid_o,
//                       frame_err_o, busy_o, receive_led_o out)
//  Parameters  : CLKS_PER_BIT    clock cycles per UART bit (>= 4)
//                LED_HOLD_CYCLES LED hold time after an accepted byte (>= 1)
//  Options     : UART_PARITY_EN  when defined, an even-parity bit follows
//                                the data bits (11-bit frame)
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_cfg_rx #(
  parameter int CLKS_PER_BIT    = 104,
  parameter int LED_HOLD_CYCLES = 1200000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  uart_cfg_rx_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(LED_HOLD_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LED_HOLD_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic          sync1, rx_s;
  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          at_mid, at_last;
  logic          busy, accept, reject, par_err;
  logic [7:0]    byte_out;
  logic          valid_pulse, err_pulse;
  logic [HW-1:0] hold;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_i;
      rx_s  <= sync1;
    end
  end

  assign at_mid  = (cnt == CNT_MID);
  assign at_last = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nxt = S_START;
      S_START:  if (at_mid) state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (at_last && idx == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (at_last) state_nxt = S_STOP;
`else
      S_DATA:   if (at_last && idx == 3'd7) state_nxt = S_STOP;
`endif
      // Leaving STOP right at the mid-stop sample gives half a bit of slack
      // to catch a start bit that follows immediately.
      S_STOP:   if (at_last) state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: frame verdict is taken at the mid-stop sample
  always_comb begin
    busy   = (state != S_IDLE);
    accept = 1'b0;
    reject = 1'b0;
    if (state == S_STOP && at_last) begin
      accept = rx_s & ~par_err;
      reject = ~rx_s | par_err;
    end
  end

  // Bit timing, data index and shift register. cnt is phase-aligned so the
  // START wait ends at mid-bit and every later sample lands mid-bit too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
      sh  <= 8'h00;
    end else begin
      case (state)
        S_START: begin
          cnt <= at_mid ? '0 : cnt + 1'b1;
          if (at_mid) idx <= 3'd0;
        end
`ifdef UART_PARITY_EN
        S_DATA, S_PARITY, S_STOP: begin
`else
        S_DATA, S_STOP: begin
`endif
          cnt <= at_last ? '0 : cnt + 1'b1;
          if (state == S_DATA && at_last) begin
            sh  <= {rx_s, sh[7:1]};
            idx <= idx + 3'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            par_bit <= 1'b0;
    else if (state == S_PARITY && at_last) par_bit <= rx_s;
  end

  // Even parity: data bits plus parity bit must XOR to zero
  assign par_err = ^{sh, par_bit};
`else
  assign par_err = 1'b0;
`endif

  // Registered strobes, byte holding register and LED hold counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_out    <= 8'h00;
      valid_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      hold        <= '0;
    end else begin
      valid_pulse <= accept;
      err_pulse   <= reject;
      if (accept) byte_out <= sh;
      if (accept)            hold <= HOLD_LOAD;
      else if (hold != '0)   hold <= hold - 1'b1;
    end
  end

  assign bus.data_o        = byte_out;
  assign bus.valid_o       = valid_pulse;
  assign bus.frame_err_o   = err_pulse;
  assign bus.busy_o        = busy;
  assign bus.receive_led_o = busy | (hold != '0);

endmodule

`default_nettype wire
